// File: rtl/gbe_tx_vld_ctr.sv
// ---------------------------------------------------------------------------
// gbe_tx_vld_ctr
//
// Statistics stage for the user-side TX handshake of a 10GbE core. It counts
// accepted words and completed frames, and tracks the last and longest frame
// lengths. It also keeps sticky error flags. All outputs are registered and
// feed the software-visible status register.
//
// Ports
//   user_clk        in   user clock (every register is on this clock)
//   user_rst        in   synchronous active-high reset
//   ctr_rst         in   software clear level; only its rising edge acts
//   ctr_en          in   count enable (1 = counting)
//   tx_valid        in   word accepted by the core this cycle
//   tx_end_of_frame in   last word of a frame (qualified by tx_valid)
//   tx_afull        in   core TX FIFO almost full
//   tx_overflow     in   core TX FIFO overflow pulse
//   vld_count       out  valid words accepted
//   frame_count     out  frames completed
//   last_frame_len  out  length of the most recent completed frame
//   max_frame_len   out  longest frame since the last clear
//   err_flags       out  sticky: [0] overflow, [1] valid while afull,
//                        [2] counter wrap/saturate, [3] length saturated
// ---------------------------------------------------------------------------
module gbe_tx_vld_ctr #(
    parameter int C_CNT_WIDTH = 32,
    parameter int C_LEN_WIDTH = 16,
    parameter int C_SATURATE  = 0
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic                   ctr_rst,
    input  logic                   ctr_en,
    input  logic                   tx_valid,
    input  logic                   tx_end_of_frame,
    input  logic                   tx_afull,
    input  logic                   tx_overflow,
    output logic [C_CNT_WIDTH-1:0] vld_count,
    output logic [C_CNT_WIDTH-1:0] frame_count,
    output logic [C_LEN_WIDTH-1:0] last_frame_len,
    output logic [C_LEN_WIDTH-1:0] max_frame_len,
    output logic [3:0]             err_flags
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_e;

    localparam logic [C_CNT_WIDTH-1:0] CNT_ZERO = {C_CNT_WIDTH{1'b0}};
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = C_CNT_WIDTH'(1);
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX  = {C_CNT_WIDTH{1'b1}};
    localparam logic [C_LEN_WIDTH-1:0] LEN_ZERO = {C_LEN_WIDTH{1'b0}};
    localparam logic [C_LEN_WIDTH-1:0] LEN_ONE  = C_LEN_WIDTH'(1);
    localparam logic [C_LEN_WIDTH-1:0] LEN_MAX  = {C_LEN_WIDTH{1'b1}};

    // Counter increment. The MSB of the result flags an attempted
    // overflow; the low bits are the wrapped or held next value.
    function automatic logic [C_CNT_WIDTH:0] cnt_inc(input logic [C_CNT_WIDTH-1:0] val);
        logic [C_CNT_WIDTH:0] res;
        if (val == CNT_MAX) begin
            if (C_SATURATE != 0) begin
                res = {1'b1, CNT_MAX};
            end else begin
                res = {1'b1, CNT_ZERO};
            end
        end else begin
            res = {1'b0, val + CNT_ONE};
        end
        return res;
    endfunction

    // Saturating length increment.
    function automatic logic [C_LEN_WIDTH-1:0] len_inc(input logic [C_LEN_WIDTH-1:0] val);
        logic [C_LEN_WIDTH-1:0] res;
        if (val == LEN_MAX) begin
            res = LEN_MAX;
        end else begin
            res = val + LEN_ONE;
        end
        return res;
    endfunction

    state_e                 state_q, state_d;
    logic [C_LEN_WIDTH-1:0] cur_len_q, cur_len_d;
    logic                   ctr_rst_q;
    logic [C_CNT_WIDTH-1:0] vld_q, vld_d;
    logic [C_CNT_WIDTH-1:0] frm_q, frm_d;
    logic [C_LEN_WIDTH-1:0] last_q, last_d;
    logic [C_LEN_WIDTH-1:0] max_q, max_d;
    logic [3:0]             err_q, err_d;

    logic                   clr_s;
    logic                   done_s;
    logic [C_LEN_WIDTH-1:0] done_len_s;
    logic [C_LEN_WIDTH-1:0] len_plus_s;
    logic                   len_sat_s;
    logic                   word_cnt_s;
    logic                   frm_cnt_s;
    logic [C_CNT_WIDTH:0]   vld_inc_s;
    logic [C_CNT_WIDTH:0]   frm_inc_s;
    logic                   wrap_s;
    logic [C_LEN_WIDTH-1:0] max_base_s;

    assign clr_s      = ctr_rst & ~ctr_rst_q;
    assign len_plus_s = len_inc(cur_len_q);
    assign vld_inc_s  = cnt_inc(vld_q);
    assign frm_inc_s  = cnt_inc(frm_q);

    // Frame FSM: tracks the in-flight frame length independent of ctr_en.
    always_comb begin
        state_d    = state_q;
        cur_len_d  = cur_len_q;
        done_s     = 1'b0;
        done_len_s = LEN_ZERO;
        len_sat_s  = 1'b0;
        if (tx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_end_of_frame) begin
                        done_s     = 1'b1;
                        done_len_s = LEN_ONE;
                    end else begin
                        state_d   = ST_IN_FRAME;
                        cur_len_d = LEN_ONE;
                    end
                end
                ST_IN_FRAME: begin
                    if (tx_end_of_frame) begin
                        done_s     = 1'b1;
                        done_len_s = len_plus_s;
                        state_d    = ST_IDLE;
                        cur_len_d  = LEN_ZERO;
                    end else begin
                        cur_len_d = len_plus_s;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cur_len_d = LEN_ZERO;
                end
            endcase
            // Saturation is flagged whenever a tracked length lands on all-ones.
            if (done_s) begin
                len_sat_s = (done_len_s == LEN_MAX);
            end else begin
                len_sat_s = (cur_len_d == LEN_MAX);
            end
        end else begin
            state_d   = state_q;
            cur_len_d = cur_len_q;
        end
    end

    // Statistics next-state: on a clear the base is zero but a coincident
    // event still contributes, so nothing that happens in the clear cycle is lost.
    always_comb begin
        word_cnt_s = tx_valid & ctr_en;
        frm_cnt_s  = done_s & ctr_en;
        wrap_s     = 1'b0;
        vld_d      = vld_q;
        frm_d      = frm_q;
        last_d     = last_q;
        max_base_s = max_q;
        max_d      = max_q;

        if (clr_s) begin
            vld_d      = word_cnt_s ? CNT_ONE : CNT_ZERO;
            frm_d      = frm_cnt_s ? CNT_ONE : CNT_ZERO;
            last_d     = frm_cnt_s ? done_len_s : LEN_ZERO;
            max_base_s = LEN_ZERO;
        end else begin
            if (word_cnt_s) begin
                vld_d  = vld_inc_s[C_CNT_WIDTH-1:0];
                wrap_s = wrap_s | vld_inc_s[C_CNT_WIDTH];
            end else begin
                vld_d = vld_q;
            end
            if (frm_cnt_s) begin
                frm_d  = frm_inc_s[C_CNT_WIDTH-1:0];
                wrap_s = wrap_s | frm_inc_s[C_CNT_WIDTH];
                last_d = done_len_s;
            end else begin
                frm_d  = frm_q;
                last_d = last_q;
            end
        end

        if (frm_cnt_s && (done_len_s > max_base_s)) begin
            max_d = done_len_s;
        end else begin
            max_d = max_base_s;
        end

        err_d = (clr_s ? 4'b0000 : err_q)
              | {len_sat_s, wrap_s, tx_valid & tx_afull, tx_overflow};
    end

    // State, edge detector and statistics registers with synchronous reset.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q   <= ST_IDLE;
            cur_len_q <= LEN_ZERO;
            ctr_rst_q <= 1'b0;
            vld_q     <= CNT_ZERO;
            frm_q     <= CNT_ZERO;
            last_q    <= LEN_ZERO;
            max_q     <= LEN_ZERO;
            err_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cur_len_q <= cur_len_d;
            ctr_rst_q <= ctr_rst;
            vld_q     <= vld_d;
            frm_q     <= frm_d;
            last_q    <= last_d;
            max_q     <= max_d;
            err_q     <= err_d;
        end
    end

    assign vld_count      = vld_q;
    assign frame_count    = frm_q;
    assign last_frame_len = last_q;
    assign max_frame_len  = max_q;
    assign err_flags      = err_q;

endmodule
